audio_recorder: RTL and testbench

AUDIO_RECORDER -- requirements
Module: audio_recorder

---
 rtl/audio_rec_pkg.sv | 22 ++
 rtl/audio_sample_pack.sv | 54 +++++
 rtl/audio_recorder.sv | 126 ++++++++++++
 tb/tb_audio_recorder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_rec_pkg.sv
// Shared definitions for the audio recorder: recorder FSM states, parameter defaults, codec alignment.
// Latency: none (declarations only).
// Backpressure: not applicable.
package audio_rec_pkg;

    // Default sample memory geometry: 128K words of 16-bit samples.
    localparam int ADDR_W_DEFAULT   = 17;
    localparam int SAMPLE_W_DEFAULT = 16;

    // The codec delivers samples left-aligned at bit 14 of a 32-bit word.
    // Playback packs a stored word as {sample, 14'b0}; recording undoes that shift.
    localparam int SAMPLE_SHIFT = 14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_POP   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/audio_sample_pack.sv
// Converts a pair of 32-bit codec channel words into one stored sample word.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   left, right : 32-bit codec channel words, sample field at [SAMPLE_SHIFT +: SAMPLE_W]
//   sample      : SAMPLE_W-bit word to store
//
// Build option AUDIO_RECORDER_MONO_MIX_EN:
//   defined   -> sample is the average of both channels, (L + R) >>> 1 over a
//                (SAMPLE_W+1)-bit signed sum so the addition cannot overflow.
//   undefined -> sample is the left channel field; right is ignored.
module audio_sample_pack
    import audio_rec_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic [31:0]         left,
    input  logic [31:0]         right,
    output logic [SAMPLE_W-1:0] sample
);

    localparam int FIELD_TOP = SAMPLE_SHIFT + SAMPLE_W;

    logic [SAMPLE_W-1:0] left_field;

    assign left_field = left[SAMPLE_SHIFT +: SAMPLE_W];

`ifdef AUDIO_RECORDER_MONO_MIX_EN
    logic [SAMPLE_W-1:0] right_field;
    logic [SAMPLE_W:0]   mix_sum;
    logic                unused_bits;

    assign right_field = right[SAMPLE_SHIFT +: SAMPLE_W];

    // Sign-extend both fields by one bit so the sum is exact, then drop the
    // LSB: that is an arithmetic shift right by one of the 17-bit sum.
    assign mix_sum = {left_field[SAMPLE_W-1], left_field}
                   + {right_field[SAMPLE_W-1], right_field};
    assign sample  = mix_sum[SAMPLE_W:1];

    // Bits outside the sample field carry codec padding only.
    assign unused_bits = ^{left[31:FIELD_TOP], left[SAMPLE_SHIFT-1:0],
                           right[31:FIELD_TOP], right[SAMPLE_SHIFT-1:0]};
`else
    logic unused_bits;

    assign sample = left_field;

    // Mono-left build: right channel and the padding bits are not used.
    assign unused_bits = ^{left[31:FIELD_TOP], left[SAMPLE_SHIFT-1:0], right};
`endif

endmodule

// File: rtl/audio_recorder.sv
// Records codec samples into a sample RAM, keeping one word per DECIM popped samples.
// Latency: available seen in WAIT at cycle N -> read_audio_in at N+1 -> mem_wren at N+2.
// Backpressure: waits in WAIT while audio_in_available is low; RAM writes are never stalled.
//
// Ports:
//   CLOCK_50, reset_n        : system clock, asynchronous active-low reset
//   start, stop              : level controls; start records from address 0, stop ends it
//   audio_in_available       : codec input FIFO non-empty
//   left/right_channel_audio_in : codec sample words
//   read_audio_in            : one-cycle codec FIFO pop
//   mem_address/data/wren    : sample RAM write port
//   busy, full, sample_count : status
//
// Build option AUDIO_RECORDER_MONO_MIX_EN selects a left/right average instead of
// left-only storage (see audio_sample_pack).
module audio_recorder
    import audio_rec_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int DECIM    = 3
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    input  logic [31:0]         right_channel_audio_in,
    output logic                read_audio_in,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [SAMPLE_W-1:0] mem_data,
    output logic                mem_wren,
    output logic                busy,
    output logic                full,
    output logic [ADDR_W:0]     sample_count
);

    localparam int                CNT_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

    state_t            state;
    logic [CNT_W-1:0]  dec_cnt;
    logic [31:0]       left_q;
    logic [31:0]       right_q;

    // Strobes and busy decode straight from the state register so that an
    // asynchronous reset drops them in the same instant, aborting any write.
    assign read_audio_in = (state == ST_POP);
    assign mem_wren      = (state == ST_WRITE);
    assign busy          = (state == ST_WAIT) || (state == ST_POP) || (state == ST_WRITE);

    // The word to store is built from the channels latched in WAIT; the
    // latches reset to zero so mem_data reads zero out of reset.
    audio_sample_pack #(
        .SAMPLE_W (SAMPLE_W)
    ) u_pack (
        .left   (left_q),
        .right  (right_q),
        .sample (mem_data)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            dec_cnt      <= '0;
            mem_address  <= '0;
            sample_count <= '0;
            full         <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // stop has priority over start; status holds until a start.
                    if (start && !stop) begin
                        dec_cnt      <= '0;
                        mem_address  <= '0;
                        sample_count <= '0;
                        full         <= 1'b0;
                        state        <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (audio_in_available) begin
                        left_q  <= left_channel_audio_in;
                        right_q <= right_channel_audio_in;
                        state   <= ST_POP;
                    end
                end

                ST_POP: begin
                    // A zero count means this popped sample is the one kept;
                    // the write is finished even if stop is already high.
                    if (dec_cnt == '0) begin
                        state <= ST_WRITE;
                    end else begin
                        dec_cnt <= dec_cnt - CNT_W'(1);
                        state   <= stop ? ST_IDLE : ST_WAIT;
                    end
                end

                ST_WRITE: begin
                    dec_cnt      <= CNT_RELOAD;
                    sample_count <= sample_count + (ADDR_W + 1)'(1);
                    if (mem_address == ADDR_LAST) begin
                        // Last RAM location just written: hold the address
                        // rather than wrap onto the start of the recording.
                        full  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        mem_address <= mem_address + ADDR_W'(1);
                        state       <= stop ? ST_IDLE : ST_WAIT;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_recorder.sv
// Self-checking bench for audio_recorder: randomized and directed codec traffic,
// expected RAM writes queued by a reference model, checked by a separate monitor.
module tb_audio_recorder;

    localparam int AW  = 4;
    localparam int SW  = 16;
    localparam int DEC = 3;

    logic          CLOCK_50;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic          audio_in_available;
    logic [31:0]   left_channel_audio_in;
    logic [31:0]   right_channel_audio_in;
    logic          read_audio_in;
    logic [AW-1:0] mem_address;
    logic [SW-1:0] mem_data;
    logic          mem_wren;
    logic          busy;
    logic          full;
    logic [AW:0]   sample_count;

    audio_recorder #(
        .ADDR_W   (AW),
        .SAMPLE_W (SW),
        .DECIM    (DEC)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .reset_n                (reset_n),
        .start                  (start),
        .stop                   (stop),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .read_audio_in          (read_audio_in),
        .mem_address            (mem_address),
        .mem_data               (mem_data),
        .mem_wren               (mem_wren),
        .busy                   (busy),
        .full                   (full),
        .sample_count           (sample_count)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    int n_checks = 0;
    int n_errors = 0;

    wr_t         exp_q[$];
    int          wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int          wr_seen  = 0;
    int          pop_seen = 0;

    // Reference model state: samples popped and words stored since start.
    int m_pops   = 0;
    int m_stored = 0;
    bit m_full   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Stored word from codec words, by plain integer arithmetic on the fields.
    function automatic logic [15:0] expected_word(input logic [31:0] l, input logic [31:0] r);
        int lf;
        int rf;
        lf = int'((l >> 14) & 32'hFFFF);
        rf = int'((r >> 14) & 32'hFFFF);
        if (lf >= 32768) lf -= 65536;
        if (rf >= 32768) rf -= 65536;
`ifdef AUDIO_RECORDER_MONO_MIX_EN
        begin
            int s;
            s = (lf + rf) >>> 1;
            return s[15:0];
        end
`else
        if (rf > 65536) $display("note: unreachable");
        return lf[15:0];
`endif
    endfunction

    task automatic model_start();
        m_pops   = 0;
        m_stored = 0;
        m_full   = 0;
    endtask

    // Sample index 0, DEC, 2*DEC, ... after start is stored at the next address.
    task automatic model_pop(input logic [31:0] l, input logic [31:0] r);
        wr_t e;
        if (!m_full && (m_pops % DEC) == 0) begin
            e.addr = m_stored;
            e.data = expected_word(l, r);
            exp_q.push_back(e);
            m_stored++;
            if (m_stored == (1 << AW)) m_full = 1;
        end
        m_pops++;
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge CLOCK_50) begin
        if (read_audio_in) pop_seen++;
        if (reset_n && mem_wren) begin
            wr_t e;
            wr_seen++;
            wr_addr_log.push_back(int'(mem_address));
            wr_data_log.push_back(mem_data);
            check("rd_wr_exclusive", {31'd0, read_audio_in}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %04h, expected no write",
                         mem_address, mem_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", {28'd0, mem_address}, e.addr);
                check("write_data", {16'd0, mem_data}, {16'd0, e.data});
            end
        end
    end

    // Present one codec sample and wait for the DUT to pop it.
    task automatic feed_one(input logic [31:0] l, input logic [31:0] r, input bit gaps);
        bit ok;
        left_channel_audio_in  = l;
        right_channel_audio_in = r;
        if (gaps) begin
            audio_in_available = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
        end
        audio_in_available = 1'b1;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLOCK_50);
            if (read_audio_in) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_timeout: got no read_audio_in in 50 cycles, expected a pop");
            audio_in_available = 1'b0;
        end else begin
            model_pop(l, r);
        end
    endtask

    task automatic feed(input int n, input bit gaps, input bit directed, input logic [31:0] base);
        logic [31:0] l;
        logic [31:0] r;
        for (int k = 0; k < n; k++) begin
            if (m_full) break;
            if (directed) begin
                l = base * (k + 1);
                r = l;
            end else begin
                l = $urandom;
                r = $urandom;
            end
            feed_one(l, r, gaps);
        end
        audio_in_available = 1'b0;
    endtask

    task automatic start_pulse();
        model_start();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},  {31'd0, read_audio_in}, 32'd0);
        check({tag, "_wren"},  {31'd0, mem_wren}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_full"},  {31'd0, full}, 32'd0);
        check({tag, "_addr"},  {28'd0, mem_address}, 32'd0);
        check({tag, "_data"},  {16'd0, mem_data}, 32'd0);
        check({tag, "_count"}, {27'd0, sample_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          pops0;
        int          wr0;
        int          a_addr [3];
        logic [15:0] a_data [3];

        a_addr[0] = 0;        a_addr[1] = 1;        a_addr[2] = 2;
        a_data[0] = 16'h0005; a_data[1] = 16'h0014; a_data[2] = 16'h0023;

        reset_n                = 1'b0;
        start                  = 1'b0;
        stop                   = 1'b0;
        audio_in_available     = 1'b0;
        left_channel_audio_in  = '0;
        right_channel_audio_in = '0;

        repeat (3) @(negedge CLOCK_50);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Nine samples L = 0x14000*k: kept samples are k = 1, 4, 7.
        base = wr_addr_log.size();
        start_pulse();
        check("start_busy", {31'd0, busy}, 32'd1);
        feed(9, 0, 1, 32'h0001_4000);
        repeat (3) @(negedge CLOCK_50);
        check("a_count", {27'd0, sample_count}, 32'd3);
        check("a_nwrites", wr_addr_log.size() - base, 32'd3);
        if (wr_addr_log.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                check("a_addr", wr_addr_log[base + i], a_addr[i]);
                check("a_data", {16'd0, wr_data_log[base + i]}, {16'd0, a_data[i]});
            end
        end

        // Single-cycle available pulse; the next pop after nine is a stored one.
        left_channel_audio_in  = $urandom;
        right_channel_audio_in = $urandom;
        check("lat_wait_nopop", {31'd0, read_audio_in}, 32'd0);
        audio_in_available = 1'b1;
        @(negedge CLOCK_50);
        audio_in_available = 1'b0;
        check("lat_pop_n1", {31'd0, read_audio_in}, 32'd1);
        check("lat_nowr_n1", {31'd0, mem_wren}, 32'd0);
        if (read_audio_in) model_pop(left_channel_audio_in, right_channel_audio_in);
        @(negedge CLOCK_50);
        check("lat_wr_n2", {31'd0, mem_wren}, 32'd1);
        @(negedge CLOCK_50);
        check("lat_count", {27'd0, sample_count}, 32'd4);

        // stop in WAIT returns to IDLE; count holds.
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        check("stopwait_busy", {31'd0, busy}, 32'd0);
        check("stopwait_count", {27'd0, sample_count}, 32'd4);

        // Randomized run with gaps and random padding bits.
        start_pulse();
        feed($urandom_range(8, 14), 1, 0, 32'd0);
        repeat (4) @(negedge CLOCK_50);
        check("rand_count", {27'd0, sample_count}, m_stored);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        check("rand_stop_busy", {31'd0, busy}, 32'd0);

        // Fill the whole memory.
        start_pulse();
        feed(60, 0, 0, 32'd0);
        repeat (4) @(negedge CLOCK_50);
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_busy", {31'd0, busy}, 32'd0);
        check("full_count", {27'd0, sample_count}, 32'd16);
        check("full_addr", {28'd0, mem_address}, 32'd15);
        pops0 = pop_seen;
        audio_in_available = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        audio_in_available = 1'b0;
        check("done_no_pop", pop_seen - pops0, 32'd0);
        check("done_full_hold", {31'd0, full}, 32'd1);
        start_pulse();
        check("restart_full", {31'd0, full}, 32'd0);
        check("restart_count", {27'd0, sample_count}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);

        // stop coincident with a storing POP: write completes, then IDLE.
        feed_one($urandom, $urandom, 0);
        stop = 1'b1;
        audio_in_available = 1'b0;
        @(negedge CLOCK_50);
        check("stoppop_wren", {31'd0, mem_wren}, 32'd1);
        @(negedge CLOCK_50);
        check("stoppop_busy", {31'd0, busy}, 32'd0);
        check("stoppop_count", {27'd0, sample_count}, 32'd1);
        stop = 1'b0;

        // start together with stop in IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check("startstop_busy", {31'd0, busy}, 32'd0);
        check("startstop_count", {27'd0, sample_count}, 32'd1);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge CLOCK_50);

`ifdef AUDIO_RECORDER_MONO_MIX_EN
        base = wr_data_log.size();
        start_pulse();
        feed_one(32'h1FFF_C000, 32'h0000_4000, 0);
        audio_in_available = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("mix_pos_n", wr_data_log.size() - base, 32'd1);
        if (wr_data_log.size() > base) check("mix_pos", {16'd0, wr_data_log[base]}, 32'h4000);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        base = wr_data_log.size();
        start_pulse();
        feed_one(32'h2000_0000, 32'h2000_0000, 0);
        audio_in_available = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("mix_neg_n", wr_data_log.size() - base, 32'd1);
        if (wr_data_log.size() > base) check("mix_neg", {16'd0, wr_data_log[base]}, 32'h8000);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
`endif

        // Reset in the middle of a WRITE.
        start_pulse();
        feed_one($urandom, $urandom, 0);
        audio_in_available = 1'b0;
        @(negedge CLOCK_50);
        check("rstw_wren", {31'd0, mem_wren}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("rstw");
        exp_q.delete();
        model_start();
        wr0 = wr_seen;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check("rstw_no_wren", wr_seen - wr0, 32'd0);
        check("rstw_busy", {31'd0, busy}, 32'd0);

        check("exp_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
